// File: rtl/edge_event_pkg.sv
// Shared defaults and CSR-side configuration type for the edge event detector.
package edge_event_pkg;

    localparam int unsigned EDGE_EVENT_NUM_CH = 8;
    localparam int unsigned EDGE_EVENT_FILT_W = 4;

    typedef struct packed {
        logic posedge_en;
        logic negedge_en;
    } edge_cfg_t;

endpackage

// File: rtl/dff.sv
// Single-flop sampler: used when the input is already near-synchronous.
module dff (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic d_i,
    output logic q_o
);

    logic q_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            q_q <= 1'b0;
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/dual_synchronizer.sv
// Two-flop synchroniser for a single asynchronous input bit.
module dual_synchronizer (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/edge_filter_ch.sv
// One channel: synchroniser, optional glitch filter (EDGE_EVENT_DETECTOR_FILTER_EN),
// stable level register, edge pulses and sticky event bit.
module edge_filter_ch
    import edge_event_pkg::*;
#(
    parameter int unsigned FILT_W = EDGE_EVENT_FILT_W,
    parameter bit          ASYNC  = 1'b1
) (
    input  logic              clk_i,
    input  logic              arst_ni,
    input  logic              d_i,
    input  logic              posedge_en_i,
    input  logic              negedge_en_i,
    input  logic [FILT_W-1:0] filt_len_i,
    input  logic              clear_i,
    output logic              level_o,
    output logic              posedge_o,
    output logic              negedge_o,
    output logic              event_o
);

    logic s;
    logic qualify;
    logic level_q, level_d;
    logic event_q, event_d;

    if (ASYNC) begin : g_sync2
        dual_synchronizer u_sync (
            .clk_i   (clk_i),
            .arst_ni (arst_ni),
            .d_i     (d_i),
            .q_o     (s)
        );
    end else begin : g_sync1
        dff u_sync (
            .clk_i   (clk_i),
            .arst_ni (arst_ni),
            .d_i     (d_i),
            .q_o     (s)
        );
    end

`ifdef EDGE_EVENT_DETECTOR_FILTER_EN
    logic [FILT_W-1:0] cnt_q, cnt_d;

    // >= so a lowered filt_len_i qualifies on the next differing sample.
    assign qualify = (s != level_q) && (cnt_q >= filt_len_i);

    always_comb begin
        cnt_d = cnt_q;
        if ((s == level_q) || qualify) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + FILT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_filt_len;
    assign unused_filt_len = ^filt_len_i;
    assign qualify         = (s != level_q);
`endif

    always_comb begin
        level_d   = qualify ? s : level_q;
        posedge_o = qualify & s & posedge_en_i;
        negedge_o = qualify & ~s & negedge_en_i;
        // A new pulse beats a simultaneous clear.
        event_d   = (event_q & ~clear_i) | posedge_o | negedge_o;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            level_q <= 1'b0;
            event_q <= 1'b0;
        end else begin
            level_q <= level_d;
            event_q <= event_d;
        end
    end

    assign level_o = level_q;
    assign event_o = event_q;

endmodule

// File: rtl/edge_event_detector.sv
// Multi-channel edge detector with sticky events and a combined interrupt.
// Glitch filtering is built only when EDGE_EVENT_DETECTOR_FILTER_EN is defined.
module edge_event_detector
    import edge_event_pkg::*;
#(
    parameter int unsigned NUM_CH = EDGE_EVENT_NUM_CH,
    parameter int unsigned FILT_W = EDGE_EVENT_FILT_W,
    parameter bit          ASYNC  = 1'b1
) (
    input  logic              arst_ni,
    input  logic              clk_i,
    input  logic [NUM_CH-1:0] d_i,
    input  logic [NUM_CH-1:0] posedge_en_i,
    input  logic [NUM_CH-1:0] negedge_en_i,
    input  logic [FILT_W-1:0] filt_len_i,
    input  logic [NUM_CH-1:0] clear_i,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] posedge_o,
    output logic [NUM_CH-1:0] negedge_o,
    output logic [NUM_CH-1:0] event_o,
    output logic              irq_o
);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        edge_filter_ch #(
            .FILT_W (FILT_W),
            .ASYNC  (ASYNC)
        ) u_ch (
            .clk_i        (clk_i),
            .arst_ni      (arst_ni),
            .d_i          (d_i[ch]),
            .posedge_en_i (posedge_en_i[ch]),
            .negedge_en_i (negedge_en_i[ch]),
            .filt_len_i   (filt_len_i),
            .clear_i      (clear_i[ch]),
            .level_o      (level_o[ch]),
            .posedge_o    (posedge_o[ch]),
            .negedge_o    (negedge_o[ch]),
            .event_o      (event_o[ch])
        );
    end

    assign irq_o = |event_o;

endmodule
